// File: rtl/exception_vector_seq.sv
// Exception sequencer for a multicycle CPU: steers the memory address mux to a vector slot,
// saves EPC, and loads PC with the handler byte. Optional feature macro: EXC_CAUSE_REG_EN.
module exception_vector_seq #(
    parameter int unsigned MEM_WAIT  = 1,
    parameter logic [31:0] PC_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ctrl_addr_sel,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data,
    output logic [2:0]  addr_sel,
    output logic [31:0] epc_out,
    output logic        epc_write,
    output logic [31:0] pc_out,
    output logic        pc_write,
`ifdef EXC_CAUSE_REG_EN
    output logic [1:0]  cause,
    output logic        nested_exc,
`endif
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, SAVE, FETCH, LOAD} state_t;

    state_t      state;
    logic [2:0]  vec_code;
    logic [2:0]  wait_cnt;
    logic [2:0]  exc_code;
    logic        any_exc;
    logic        fetch_done;
    logic        unused_mem_bits;

    function automatic logic [31:0] calc_epc(input logic [31:0] pc);
        return pc - PC_OFFSET;
    endfunction

    assign any_exc         = exc_opcode | exc_overflow | exc_divzero;
    assign fetch_done      = (4'({1'b0, wait_cnt}) + 4'd1) == 4'(MEM_WAIT);
    assign unused_mem_bits = ^mem_data[31:8];

    // Fixed priority: opcode > overflow > divzero (vector slots 253/254/255).
    always_comb begin
        exc_code = 3'b100;
        if (exc_opcode)
            exc_code = 3'b010;
        else if (exc_overflow)
            exc_code = 3'b011;
    end

    // Idle pass-through is combinational so normal operation sees no added latency.
    always_comb begin
        addr_sel = vec_code;
        if (state == IDLE)
            addr_sel = reset ? ctrl_addr_sel : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            vec_code  <= 3'b000;
            wait_cnt  <= 3'd0;
            epc_out   <= 32'd0;
            pc_out    <= 32'd0;
            epc_write <= 1'b0;
            pc_write  <= 1'b0;
            stall     <= 1'b0;
`ifdef EXC_CAUSE_REG_EN
            cause      <= 2'b00;
            nested_exc <= 1'b0;
`endif
        end else begin
            epc_write <= 1'b0;
            pc_write  <= 1'b0;
`ifdef EXC_CAUSE_REG_EN
            nested_exc <= any_exc && (state != IDLE);
`endif
            case (state)
                IDLE: begin
                    if (any_exc) begin
                        state     <= SAVE;
                        vec_code  <= exc_code;
                        epc_out   <= calc_epc(pc_in);
                        epc_write <= 1'b1;
                        stall     <= 1'b1;
`ifdef EXC_CAUSE_REG_EN
                        cause     <= exc_code[1:0] + 2'b11;
`endif
                    end
                end
                SAVE: begin
                    wait_cnt <= 3'd0;
                    state    <= FETCH;
                end
                FETCH: begin
                    // Handler address is the low byte of the vector slot.
                    wait_cnt <= wait_cnt + 3'd1;
                    if (fetch_done) begin
                        pc_out   <= {24'd0, mem_data[7:0]};
                        pc_write <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_vector_seq.sv
// Randomized bench for exception_vector_seq against a cycle-count reference model.
module tb_exception_vector_seq;

    localparam int MW = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  ctrl_addr_sel = 3'd0;
    logic        exc_opcode = 1'b0;
    logic        exc_overflow = 1'b0;
    logic        exc_divzero = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic [31:0] mem_data = 32'd0;
    logic [2:0]  addr_sel;
    logic [31:0] epc_out;
    logic        epc_write;
    logic [31:0] pc_out;
    logic        pc_write;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: k counts cycles since exception detection (0 = not sequencing).
    int          k = 0;
    logic [2:0]  m_vec = 3'd0;
    logic [31:0] m_epc = 32'd0;
    logic [31:0] m_pc  = 32'd0;

    exception_vector_seq #(.MEM_WAIT(MW), .PC_OFFSET(32'd4)) dut (
        .clk(clk), .reset(reset), .ctrl_addr_sel(ctrl_addr_sel),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_divzero(exc_divzero),
        .pc_in(pc_in), .mem_data(mem_data), .addr_sel(addr_sel),
        .epc_out(epc_out), .epc_write(epc_write), .pc_out(pc_out),
        .pc_write(pc_write), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            k     = 0;
            m_epc = 32'd0;
            m_pc  = 32'd0;
        end else if (k == 0) begin
            if (exc_opcode || exc_overflow || exc_divzero) begin
                k     = 1;
                m_vec = exc_opcode ? 3'd2 : (exc_overflow ? 3'd3 : 3'd4);
                m_epc = pc_in - 32'd4;
            end
        end else begin
            if (k == MW + 1)
                m_pc = {24'd0, mem_data[7:0]};
            k = (k == MW + 2) ? 0 : k + 1;
        end
    endtask

    task automatic cycle(input logic r, input logic [2:0] c, input logic eo, input logic ev,
                         input logic ed, input logic [31:0] pc, input logic [31:0] md);
        logic [2:0] exp_sel;
        @(negedge clk);
        reset = r; ctrl_addr_sel = c; exc_opcode = eo; exc_overflow = ev;
        exc_divzero = ed; pc_in = pc; mem_data = md;
        #1;
        exp_sel = (k == 0) ? (r ? c : 3'd0) : m_vec;
        check("addr_sel", {29'd0, addr_sel}, {29'd0, exp_sel});
        check("stall", {31'd0, stall}, {31'd0, k != 0});
        check("epc_write", {31'd0, epc_write}, {31'd0, k == 1});
        check("pc_write", {31'd0, pc_write}, {31'd0, k == MW + 2});
        check("epc_out", epc_out, m_epc);
        check("pc_out", pc_out, m_pc);
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        @(posedge clk);
        model_edge();
        // Reset held with an exception pending, then pass-through.
        cycle(1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        cycle(1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        cycle(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        // Overflow vector.
        cycle(1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h40, 32'hA7);
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h40, 32'hA7);
        // Simultaneous exceptions resolve to opcode.
        cycle(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h33);
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 32'h100, 32'h33);
        // Divzero with EPC wraparound and upper data bits discarded.
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFFFF80);
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFFFF80);
        // Exception during FETCH is ignored.
        cycle(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h5A);
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h5A);
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h5A);
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 32'h200, 32'h5A);
        // Reset during FETCH aborts the sequence.
        cycle(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h11);
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h11);
        cycle(1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 32'h300, 32'h11);
        cycle(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 32'h300, 32'h11);
        cycle(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h300, 32'h11);
        // Exception held high across return to IDLE.
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h400 + i, 32'hC0 + i);
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 59) != 0, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom, $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
